// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer between the UART RX controller and the bus. Received bytes
//   arrive as single-cycle pulses and are stored in a circular FIFO. The FIFO
//   presents them as a first-word-fall-through valid/ready stream. It also
//   keeps sticky overflow, frame-error and break status, and an almost-full
//   flag that feeds RTS flow control.
//
// Ports
//   io_mainClk             clock, rising edge
//   resetCtrl_systemReset  synchronous active-high reset
//   io_push_valid/payload  received byte strobe + data (no backpressure)
//   io_rxError             frame/parity error pulse
//   io_rxBreak             break condition level
//   io_pop_valid/ready/payload  FWFT output stream
//   io_occupancy           entries stored, 0..DEPTH
//   io_almostFull          occupancy >= AFULL_LEVEL
//   io_overflow            sticky: a push was dropped on a full FIFO
//   io_errorCount          saturating count of rxError pulses
//   io_breakSeen           sticky: rising edge of rxBreak seen
//   io_flush               empty the FIFO in one cycle
//   io_clearFlags          clear overflow, errorCount, breakSeen
module uart_rx_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                         io_mainClk,
  input  logic                         resetCtrl_systemReset,
  input  logic                         io_push_valid,
  input  logic [DATA_WIDTH-1:0]        io_push_payload,
  input  logic                         io_rxError,
  input  logic                         io_rxBreak,
  output logic                         io_pop_valid,
  input  logic                         io_pop_ready,
  output logic [DATA_WIDTH-1:0]        io_pop_payload,
  output logic [$clog2(DEPTH):0]       io_occupancy,
  output logic                         io_almostFull,
  output logic                         io_overflow,
  output logic [7:0]                   io_errorCount,
  output logic                         io_breakSeen,
  input  logic                         io_flush,
  input  logic                         io_clearFlags
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned OCC_W = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wrPtr;
  logic [AW-1:0]         rdPtr;
  logic [OCC_W-1:0]      occupancy;
  logic                  full;
  logic                  pushFire;
  logic                  popFire;
  logic                  overflowSet;
  logic                  breakPrev;
  logic                  breakRise;

  always_comb begin
    full        = (occupancy == OCC_W'(DEPTH));
    // Flush overrides both sides: a concurrent pop is cancelled and a
    // concurrent push is discarded without being reported as overflow.
    popFire     = io_pop_valid & io_pop_ready & ~io_flush;
    pushFire    = io_push_valid & (~full | popFire) & ~io_flush;
    overflowSet = io_push_valid & full & ~popFire & ~io_flush;
    breakRise   = io_rxBreak & ~breakPrev;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge io_mainClk) begin
    if (pushFire && !resetCtrl_systemReset) begin
      mem[wrPtr] <= io_push_payload;
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else if (io_flush) begin
      rdPtr     <= wrPtr;
      occupancy <= '0;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popFire) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushFire, popFire})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky status: a set event in the same cycle as clearFlags wins.
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      io_overflow   <= 1'b0;
      io_errorCount <= '0;
      io_breakSeen  <= 1'b0;
      breakPrev     <= 1'b0;
    end else begin
      breakPrev <= io_rxBreak;

      if (overflowSet) begin
        io_overflow <= 1'b1;
      end else if (io_clearFlags) begin
        io_overflow <= 1'b0;
      end

      if (io_clearFlags) begin
        io_errorCount <= io_rxError ? 8'd1 : 8'd0;
      end else if (io_rxError && io_errorCount != '1) begin
        io_errorCount <= io_errorCount + 8'd1;
      end

      if (breakRise) begin
        io_breakSeen <= 1'b1;
      end else if (io_clearFlags) begin
        io_breakSeen <= 1'b0;
      end
    end
  end

  always_comb begin
    io_pop_valid   = (occupancy != '0);
    io_pop_payload = mem[rdPtr];
    io_occupancy   = occupancy;
    io_almostFull  = (occupancy >= OCC_W'(AFULL_LEVEL));
  end

endmodule
